stage_if: RTL and testbench

STAGE_IF -- requirements
Module: stage_if

---
 rtl/stage_if_if.sv | 26 ++
 rtl/stage_if.sv | 129 ++++++++++++
 tb/tb_stage_if.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/stage_if_if.sv
// Fetch-stage bus: control from the ID/branch side, instruction-memory
// handshake, and the instruction/PC pair handed to ID.
interface stage_if_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc_id;
    logic        valid_id;

    // master: the fetch stage itself
    modport master (
        input  stall, redirect, redirect_pc, imem_ack, imem_rdata,
        output imem_req, imem_addr, instr, pc_id, valid_id
    );

    // slave: the environment (memory, ID stage, branch unit)
    modport slave (
        output stall, redirect, redirect_pc, imem_ack, imem_rdata,
        input  imem_req, imem_addr, instr, pc_id, valid_id
    );
endinterface

// File: rtl/stage_if.sv
// Instruction fetch stage: variable-latency memory handshake, one-entry hold
// buffer for ID back-pressure, and redirect with drop of an in-flight fetch.
module stage_if (
    input  logic       clock,
    input  logic       reset,
    stage_if_if.master bus
);
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] drop_addr, drop_addr_nxt;
    logic [31:0] hold_instr, hold_instr_nxt;
    logic [31:0] hold_pc, hold_pc_nxt;
    logic [31:0] instr_p0, instr_p0_nxt;
    logic [31:0] pc_id_p0, pc_id_p0_nxt;
    logic        vld_p0, vld_p0_nxt;

    logic [31:0] pc_inc;
    logic [31:0] target;
    logic        unused_rpc_bits;

    assign pc_inc          = pc + 32'd4;
    assign target          = {bus.redirect_pc[31:2], 2'b00};
    assign unused_rpc_bits = ^bus.redirect_pc[1:0];

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        drop_addr_nxt  = drop_addr;
        hold_instr_nxt = hold_instr;
        hold_pc_nxt    = hold_pc;
        instr_p0_nxt   = instr_p0;
        pc_id_p0_nxt   = pc_id_p0;
        vld_p0_nxt     = vld_p0;

        if (bus.redirect) begin
            instr_p0_nxt = NOP;
            pc_id_p0_nxt = 32'd0;
            vld_p0_nxt   = 1'b0;
            pc_nxt       = target;
            unique case (state)
                FETCH: begin
                    // An unanswered request must still complete at its old address.
                    if (!bus.imem_ack) begin
                        state_nxt     = DROP;
                        drop_addr_nxt = pc;
                    end
                end
                HOLD:    state_nxt = FETCH;
                DROP:    if (bus.imem_ack) state_nxt = FETCH;
                default: state_nxt = FETCH;
            endcase
        end else begin
            unique case (state)
                FETCH: begin
                    if (bus.imem_ack) begin
                        pc_nxt = pc_inc;
                        if (bus.stall) begin
                            hold_instr_nxt = bus.imem_rdata;
                            hold_pc_nxt    = pc_inc;
                            state_nxt      = HOLD;
                        end else begin
                            instr_p0_nxt = bus.imem_rdata;
                            pc_id_p0_nxt = pc_inc;
                            vld_p0_nxt   = 1'b1;
                        end
                    end else if (!bus.stall) begin
                        instr_p0_nxt = NOP;
                        pc_id_p0_nxt = 32'd0;
                        vld_p0_nxt   = 1'b0;
                    end
                end
                HOLD: begin
                    if (!bus.stall) begin
                        instr_p0_nxt = hold_instr;
                        pc_id_p0_nxt = hold_pc;
                        vld_p0_nxt   = 1'b1;
                        state_nxt    = FETCH;
                    end
                end
                DROP: begin
                    if (bus.imem_ack) state_nxt = FETCH;
                    if (!bus.stall) begin
                        instr_p0_nxt = NOP;
                        pc_id_p0_nxt = 32'd0;
                        vld_p0_nxt   = 1'b0;
                    end
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    // ---- stage boundary: fetch state and ID-facing registers ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= FETCH;
            pc         <= 32'd0;
            drop_addr  <= 32'd0;
            hold_instr <= 32'd0;
            hold_pc    <= 32'd0;
            instr_p0   <= NOP;
            pc_id_p0   <= 32'd0;
            vld_p0     <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            drop_addr  <= drop_addr_nxt;
            hold_instr <= hold_instr_nxt;
            hold_pc    <= hold_pc_nxt;
            instr_p0   <= instr_p0_nxt;
            pc_id_p0   <= pc_id_p0_nxt;
            vld_p0     <= vld_p0_nxt;
        end
    end

    assign bus.imem_req  = (state != HOLD);
    assign bus.imem_addr = (state == DROP) ? drop_addr : pc;
    assign bus.instr     = instr_p0;
    assign bus.pc_id     = pc_id_p0;
    assign bus.valid_id  = vld_p0;
endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: directed vector table, reset corner cases, and a
// randomized run against a queue-based reference model.
module tb_stage_if;
    logic clock;
    logic reset;
    int   total;
    int   bad;

    stage_if_if bus();

    stage_if dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pcid;
        logic        e_req;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vq[$];

    // Reference model: outstanding discarded request and ID-blocked words as queues
    logic [31:0] m_pc;
    logic [31:0] drop_q[$];
    logic [63:0] buf_q[$];
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pcid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic row(input logic s, input logic r, input logic [31:0] rpc,
                       input logic a, input logic [31:0] rd,
                       input logic v, input logic [31:0] ins, input logic [31:0] pcid,
                       input logic rq, input logic [31:0] ad);
        vec_t x;
        x = '{s, r, rpc, a, rd, v, ins, pcid, rq, ad};
        vq.push_back(x);
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] rpc,
                         input logic a, input logic [31:0] rd);
        bus.stall       = s;
        bus.redirect    = r;
        bus.redirect_pc = rpc;
        bus.imem_ack    = a;
        bus.imem_rdata  = rd;
    endtask

    task automatic model_reset();
        m_pc = 32'd0;
        drop_q.delete();
        buf_q.delete();
        m_valid = 1'b0;
        m_instr = 32'd0;
        m_pcid  = 32'd0;
    endtask

    function automatic logic [31:0] model_addr();
        if (drop_q.size() != 0) return drop_q[0];
        return m_pc;
    endfunction

    task automatic model_bubble();
        m_valid = 1'b0;
        m_instr = 32'd0;
        m_pcid  = 32'd0;
    endtask

    task automatic model_step(input logic s, input logic r, input logic [31:0] rpc,
                              input logic a, input logic [31:0] rd);
        logic [63:0] w;
        if (r) begin
            if (drop_q.size() != 0) begin
                if (a) drop_q.delete();
            end else if (buf_q.size() == 0 && !a) begin
                drop_q.push_back(m_pc);
            end
            buf_q.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
            model_bubble();
        end else if (buf_q.size() != 0) begin
            if (!s) begin
                w = buf_q.pop_front();
                m_instr = w[63:32];
                m_pcid  = w[31:0];
                m_valid = 1'b1;
            end
        end else if (drop_q.size() != 0) begin
            if (a) drop_q.delete();
            if (!s) model_bubble();
        end else if (a) begin
            w = {rd, m_pc + 32'd4};
            m_pc = m_pc + 32'd4;
            if (s) buf_q.push_back(w);
            else begin
                m_instr = w[63:32];
                m_pcid  = w[31:0];
                m_valid = 1'b1;
            end
        end else if (!s) begin
            model_bubble();
        end
    endtask

    initial begin
        logic        s, r, a;
        logic [31:0] rpc, rd;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

        // Reset state, before any clock edge
        #1;
        chk("rst_valid", {31'd0, bus.valid_id}, 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_pcid", bus.pc_id, 32'd0);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd1);
        chk("rst_addr", bus.imem_addr, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        //   stall redir rpc           ack rdata          valid instr          pc_id          req addr
        row(0, 0, 32'h0,          1, 32'hA000_0000, 1, 32'hA000_0000, 32'h0000_0004, 1, 32'h0000_0004);
        row(0, 0, 32'h0,          1, 32'hA000_0004, 1, 32'hA000_0004, 32'h0000_0008, 1, 32'h0000_0008);
        row(0, 0, 32'h0,          1, 32'hA000_0008, 1, 32'hA000_0008, 32'h0000_000C, 1, 32'h0000_000C);
        row(1, 0, 32'h0,          1, 32'hA000_000C, 1, 32'hA000_0008, 32'h0000_000C, 0, 32'h0);
        row(1, 0, 32'h0,          1, 32'h1111_1111, 1, 32'hA000_0008, 32'h0000_000C, 0, 32'h0);
        row(0, 0, 32'h0,          0, 32'h0,         1, 32'hA000_000C, 32'h0000_0010, 1, 32'h0000_0010);
        row(0, 0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0,         1, 32'h0000_0010);
        row(0, 0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0,         1, 32'h0000_0010);
        row(0, 0, 32'h0,          1, 32'hA000_0010, 1, 32'hA000_0010, 32'h0000_0014, 1, 32'h0000_0014);
        row(0, 0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0,         1, 32'h0000_0014);
        row(0, 0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0,         1, 32'h0000_0014);
        row(0, 0, 32'h0,          1, 32'hA000_0014, 1, 32'hA000_0014, 32'h0000_0018, 1, 32'h0000_0018);
        row(0, 1, 32'h0000_0103,  0, 32'h0,         0, 32'h0,         32'h0,         1, 32'h0000_0018);
        row(0, 0, 32'h0,          0, 32'h0,         0, 32'h0,         32'h0,         1, 32'h0000_0018);
        row(0, 0, 32'h0,          1, 32'hA000_0018, 0, 32'h0,         32'h0,         1, 32'h0000_0100);
        row(0, 0, 32'h0,          1, 32'hA000_0100, 1, 32'hA000_0100, 32'h0000_0104, 1, 32'h0000_0104);
        row(1, 0, 32'h0,          1, 32'hA000_0104, 1, 32'hA000_0100, 32'h0000_0104, 0, 32'h0);
        row(1, 1, 32'h0000_0200,  0, 32'h0,         0, 32'h0,         32'h0,         1, 32'h0000_0200);
        row(0, 0, 32'h0,          1, 32'hA000_0200, 1, 32'hA000_0200, 32'h0000_0204, 1, 32'h0000_0204);
        row(0, 1, 32'hFFFF_FFFE,  1, 32'h2222_2222, 0, 32'h0,         32'h0,         1, 32'hFFFF_FFFC);
        row(0, 0, 32'h0,          1, 32'hAFFF_FFFC, 1, 32'hAFFF_FFFC, 32'h0000_0000, 1, 32'h0000_0000);
        row(1, 0, 32'h0,          0, 32'h0,         1, 32'hAFFF_FFFC, 32'h0000_0000, 1, 32'h0000_0000);
        row(0, 1, 32'h0000_0300,  0, 32'h0,         0, 32'h0,         32'h0,         1, 32'h0000_0000);
        row(0, 1, 32'h0000_0400,  0, 32'h0,         0, 32'h0,         32'h0,         1, 32'h0000_0000);
        row(1, 0, 32'h0,          1, 32'h3333_3333, 0, 32'h0,         32'h0,         1, 32'h0000_0400);
        row(0, 0, 32'h0,          1, 32'hA000_0400, 1, 32'hA000_0400, 32'h0000_0404, 1, 32'h0000_0404);

        foreach (vq[i]) begin
            drive(vq[i].stall, vq[i].redirect, vq[i].rpc, vq[i].ack, vq[i].rdata);
            @(negedge clock);
            chk($sformatf("vec%0d_valid", i), {31'd0, bus.valid_id}, {31'd0, vq[i].e_valid});
            chk($sformatf("vec%0d_instr", i), bus.instr, vq[i].e_instr);
            chk($sformatf("vec%0d_pcid", i), bus.pc_id, vq[i].e_pcid);
            chk($sformatf("vec%0d_req", i), {31'd0, bus.imem_req}, {31'd0, vq[i].e_req});
            if (vq[i].e_req) chk($sformatf("vec%0d_addr", i), bus.imem_addr, vq[i].e_addr);
        end

        // Asynchronous reset between clock edges, then a late ack at address 0
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("async_valid", {31'd0, bus.valid_id}, 32'd0);
        chk("async_instr", bus.instr, 32'd0);
        chk("async_pcid", bus.pc_id, 32'd0);
        chk("async_addr", bus.imem_addr, 32'd0);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF);
        @(negedge clock);
        chk("inrst_valid", {31'd0, bus.valid_id}, 32'd0);
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h1234_5678);
        @(negedge clock);
        chk("late_ack_instr", bus.instr, 32'h1234_5678);
        chk("late_ack_pcid", bus.pc_id, 32'h0000_0004);
        chk("late_ack_addr", bus.imem_addr, 32'h0000_0004);

        // Randomized run against the reference model
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        reset = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            chk("rnd_valid", {31'd0, bus.valid_id}, {31'd0, m_valid});
            chk("rnd_instr", bus.instr, m_instr);
            chk("rnd_pcid", bus.pc_id, m_pcid);
            chk("rnd_req", {31'd0, bus.imem_req}, {31'd0, (buf_q.size() == 0)});
            if (buf_q.size() == 0) chk("rnd_addr", bus.imem_addr, model_addr());
            s   = ($urandom_range(0, 9) < 3);
            r   = ($urandom_range(0, 9) == 0);
            a   = ($urandom_range(0, 1) == 1);
            rpc = (n % 50 == 7) ? 32'hFFFF_FFF8 : $urandom;
            rd  = model_addr() ^ ($urandom & 32'hFFF0_0000);
            drive(s, r, rpc, a, rd);
            model_step(s, r, rpc, a, rd);
            @(negedge clock);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
